// File: rtl/dma_desc_consumer_if.sv
// Descriptor FIFO, packet stream, memory write and completion signals of the
// packet DMA descriptor consumer, grouped as one bundle.
interface dma_desc_consumer_if;
    logic        fifo_empty;
    logic [47:0] fifo_dout;
    logic        fifo_rd_en;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        pkt_ready;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        done_valid;
    logic [31:0] done_addr;
    logic [15:0] done_len;
    logic        done_err;
    logic        busy;

    modport master (
        input  fifo_empty, fifo_dout, pkt_valid, pkt_data, mem_ready,
        output fifo_rd_en, pkt_ready, mem_wren, mem_addr, mem_wdata, mem_wstrb,
               done_valid, done_addr, done_len, done_err, busy
    );

    modport slave (
        output fifo_empty, fifo_dout, pkt_valid, pkt_data, mem_ready,
        input  fifo_rd_en, pkt_ready, mem_wren, mem_addr, mem_wdata, mem_wstrb,
               done_valid, done_addr, done_len, done_err, busy
    );
endinterface

// File: rtl/dma_desc_consumer.sv
// Pops one {len, addr} descriptor per packet, writes the packet words to memory
// with a bounded per-word wait, and reports one completion per descriptor.
module dma_desc_consumer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              srst,
    dma_desc_consumer_if.master bus
);
    localparam int unsigned WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_MEM, DONE} state_e;

    state_e        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   cur_addr_q;
    logic [15:0]   len_q;
    logic [14:0]   rem_q;
    logic [WW-1:0] wcnt_q;
    logic          err_q;

    logic          mem_wren_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_wstrb_q;
    logic          done_valid_q;
    logic [31:0]   done_addr_q;
    logic [15:0]   done_len_q;
    logic          done_err_q;

    logic [16:0]   len_p3_d;
    logic [14:0]   words_d;
    logic [3:0]    tail_strb_d;
    logic          tmo_hit_d;
    logic          unused_addr_lsbs;

    assign len_p3_d         = {1'b0, bus.fifo_dout[47:32]} + 17'd3;
    assign words_d          = len_p3_d[16:2];
    assign unused_addr_lsbs = ^bus.fifo_dout[1:0];
    assign tmo_hit_d        = (MEM_TIMEOUT != 0) && (32'(wcnt_q) == MEM_TIMEOUT - 1);

    always_comb begin
        tail_strb_d = 4'hF;
        case (len_q[1:0])
            2'd1:    tail_strb_d = 4'h1;
            2'd2:    tail_strb_d = 4'h3;
            2'd3:    tail_strb_d = 4'h7;
            default: tail_strb_d = 4'hF;
        endcase
    end

    // Pop is decoded from IDLE so the FWFT head is latched on the same edge
    // that consumes it; gated by srst so reset never drains the FIFO.
    assign bus.fifo_rd_en = (state_q == IDLE) && !bus.fifo_empty && !srst;
    assign bus.pkt_ready  = (state_q == XFER);
    assign bus.busy       = (state_q != IDLE);

    assign bus.mem_wren   = mem_wren_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_addr  = done_addr_q;
    assign bus.done_len   = done_len_q;
    assign bus.done_err   = done_err_q;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cur_addr_q   <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            wcnt_q       <= '0;
            err_q        <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            done_valid_q <= 1'b0;
            done_addr_q  <= '0;
            done_len_q   <= '0;
            done_err_q   <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        addr_q     <= {bus.fifo_dout[31:2], 2'b00};
                        cur_addr_q <= {bus.fifo_dout[31:2], 2'b00};
                        len_q      <= bus.fifo_dout[47:32];
                        rem_q      <= words_d;
                        wcnt_q     <= '0;
                        err_q      <= 1'b0;
                        state_q    <= (bus.fifo_dout[47:32] == 16'd0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (bus.pkt_valid) begin
                        mem_wren_q  <= 1'b1;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= bus.pkt_data;
                        mem_wstrb_q <= (rem_q == 15'd1) ? tail_strb_d : 4'hF;
                        state_q     <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    // mem_wren_q is always set here, so mem_ready is only honoured
                    // against a live request.
                    if (bus.mem_ready) begin
                        mem_wren_q <= 1'b0;
                        cur_addr_q <= cur_addr_q + 32'd4;
                        rem_q      <= rem_q - 15'd1;
                        wcnt_q     <= '0;
                        state_q    <= (rem_q == 15'd1) ? DONE : XFER;
                    end else if (tmo_hit_d) begin
                        mem_wren_q <= 1'b0;
                        err_q      <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= DONE;
                    end else if (MEM_TIMEOUT != 0) begin
                        wcnt_q <= wcnt_q + WW'(1);
                    end
                end
                DONE: begin
                    done_valid_q <= 1'b1;
                    done_addr_q  <= addr_q;
                    done_len_q   <= len_q;
                    done_err_q   <= err_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_desc_consumer.sv
// Directed bench for dma_desc_consumer: FIFO, packet source and memory models
// around the DUT, with hand-computed expected writes and completions.
module tb_dma_desc_consumer;
    logic clk;
    logic srst;

    dma_desc_consumer_if bus();

    dma_desc_consumer #(.MEM_TIMEOUT(255)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [47:0] fq[$];
    logic [31:0] pq[$];
    logic [67:0] wq[$];
    logic [48:0] dq[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pops = 0;
    int   pop_cyc = 0;
    int   done_cyc = 0;
    int   wren_cnt = 0;
    int   prdy_cnt = 0;
    int   mr_mode = 1;
    bit   pv_rand = 1'b0;
    bit   pop_pend = 1'b0;
    bit   pkt_take = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Observe the cycle's handshakes mid-cycle; the driver applies them after
    // the following edge.
    always @(negedge clk) begin
        cyc++;
        pop_pend = bus.fifo_rd_en;
        pkt_take = bus.pkt_valid && bus.pkt_ready;
        if (bus.mem_wren && bus.mem_ready)
            wq.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
        if (bus.mem_wren) wren_cnt++;
        if (bus.pkt_ready) prdy_cnt++;
        if (bus.fifo_rd_en) begin
            pops++;
            pop_cyc = cyc;
        end
        if (bus.done_valid) begin
            dq.push_back({bus.done_addr, bus.done_len, bus.done_err});
            done_cyc = cyc;
        end
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.pkt_valid  = 1'b0;
        bus.pkt_data   = '0;
        bus.mem_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend && fq.size() > 0) void'(fq.pop_front());
            if (pkt_take && pq.size() > 0) void'(pq.pop_front());
            bus.fifo_empty = (fq.size() == 0);
            bus.fifo_dout  = (fq.size() > 0) ? fq[0] : 48'd0;
            bus.pkt_valid  = (pq.size() > 0) && (!pv_rand || $urandom_range(0, 2) != 0);
            bus.pkt_data   = (pq.size() > 0) ? pq[0] : 32'd0;
            if (mr_mode == 2) bus.mem_ready = ($urandom_range(0, 1) == 1);
            else              bus.mem_ready = (mr_mode == 1);
        end
    end

    task automatic push_desc(input logic [15:0] len, input logic [31:0] addr,
                             input logic [31:0] base, input int nw);
        fq.push_back({len, addr});
        for (int i = 0; i < nw; i++) pq.push_back(base + 32'(i));
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (dq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("done_count", 64'(dq.size()), 64'(n));
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        if (idx < wq.size()) begin
            chk($sformatf("wr%0d_addr", idx), 64'(wq[idx][67:36]), 64'(a));
            chk($sformatf("wr%0d_data", idx), 64'(wq[idx][35:4]), 64'(d));
            chk($sformatf("wr%0d_strb", idx), 64'(wq[idx][3:0]), 64'(s));
        end else begin
            chk($sformatf("wr%0d_present", idx), 64'(wq.size()), 64'(idx + 1));
        end
    endtask

    task automatic chk_done(input int idx, input logic [31:0] a, input logic [15:0] l,
                            input logic e);
        if (idx < dq.size()) begin
            chk($sformatf("done%0d_addr", idx), 64'(dq[idx][48:17]), 64'(a));
            chk($sformatf("done%0d_len", idx), 64'(dq[idx][16:1]), 64'(l));
            chk($sformatf("done%0d_err", idx), 64'(dq[idx][0]), 64'(e));
        end else begin
            chk($sformatf("done%0d_present", idx), 64'(dq.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int w0;
        int p0;
        int r0;
        int k;
        srst = 1'b1;

        // Reset: a queued descriptor must not be popped while srst is high
        push_desc(16'd16, 32'h0000_1000, 32'hA000_0000, 4);
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wren", 64'(bus.mem_wren), 64'd0);
        chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'd0);
        chk("rst_done", 64'(bus.done_valid), 64'd0);
        srst = 1'b0;

        // 1: full-word packet, memory always ready
        wait_done(1, 200);
        for (int i = 0; i < 4; i++)
            chk_wr(i, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        chk_done(0, 32'h1000, 16'd16, 1'b0);
        chk("t1_pops", 64'(pops), 64'd1);

        // 2: unaligned addr, partial tail word
        push_desc(16'd6, 32'h0000_2003, 32'hB000_0000, 2);
        wait_done(2, 200);
        chk_wr(4, 32'h2000, 32'hB000_0000, 4'hF);
        chk_wr(5, 32'h2004, 32'hB000_0001, 4'h3);
        chk_done(1, 32'h2000, 16'd6, 1'b0);

        // 3: zero-length descriptor
        w0 = wren_cnt;
        r0 = prdy_cnt;
        push_desc(16'd0, 32'h0000_3000, 32'h0, 0);
        wait_done(3, 50);
        chk("t3_done_lat", 64'(done_cyc - pop_cyc), 64'd2);
        chk("t3_no_wren", 64'(wren_cnt - w0), 64'd0);
        chk("t3_no_pkt_ready", 64'(prdy_cnt - r0), 64'd0);
        chk_done(2, 32'h3000, 16'd0, 1'b0);

        // 4: memory stalls past the timeout, then a normal descriptor
        mr_mode = 0;
        w0 = wren_cnt;
        push_desc(16'd8, 32'h0000_4000, 32'hC000_0000, 2);
        wait_done(4, 400);
        chk("t4_wren_cycles", 64'(wren_cnt - w0), 64'd255);
        chk("t4_no_write", 64'(wq.size()), 64'd6);
        chk_done(3, 32'h4000, 16'd8, 1'b1);
        pq.delete();
        mr_mode = 1;
        push_desc(16'd4, 32'h0000_4100, 32'hC100_0000, 1);
        wait_done(5, 100);
        chk_wr(6, 32'h4100, 32'hC100_0000, 4'hF);
        chk_done(4, 32'h4100, 16'd4, 1'b0);

        // 5: three queued descriptors with random gaps, including address wrap
        p0 = pops;
        pv_rand = 1'b1;
        mr_mode = 2;
        push_desc(16'd12, 32'h0000_5000, 32'h5A00_0000, 3);
        push_desc(16'd5, 32'h0000_6001, 32'h6B00_0000, 2);
        push_desc(16'd8, 32'hFFFF_FFFC, 32'h7C00_0000, 2);
        wait_done(8, 600);
        chk("t5_pops", 64'(pops - p0), 64'd3);
        chk_wr(7, 32'h5000, 32'h5A00_0000, 4'hF);
        chk_wr(8, 32'h5004, 32'h5A00_0001, 4'hF);
        chk_wr(9, 32'h5008, 32'h5A00_0002, 4'hF);
        chk_wr(10, 32'h6000, 32'h6B00_0000, 4'hF);
        chk_wr(11, 32'h6004, 32'h6B00_0001, 4'h1);
        chk_wr(12, 32'hFFFF_FFFC, 32'h7C00_0000, 4'hF);
        chk_wr(13, 32'h0000_0000, 32'h7C00_0001, 4'hF);
        chk_done(5, 32'h5000, 16'd12, 1'b0);
        chk_done(6, 32'h6000, 16'd5, 1'b0);
        chk_done(7, 32'hFFFF_FFFC, 16'd8, 1'b0);
        pv_rand = 1'b0;

        // 6: reset while waiting on memory drops the in-flight descriptor
        mr_mode = 0;
        push_desc(16'd8, 32'h0000_8000, 32'hD800_0000, 2);
        k = 0;
        while (!bus.mem_wren && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reached_wait", 64'(bus.mem_wren), 64'd1);
        push_desc(16'd4, 32'h0000_9000, 32'h0, 0);
        repeat (3) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        chk("t6_rst_wren", 64'(bus.mem_wren), 64'd0);
        chk("t6_rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("t6_rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        chk("t6_rst_done_addr", 64'(bus.done_addr), 64'd0);
        pq.delete();
        pq.push_back(32'h9000_00D0);
        mr_mode = 1;
        @(negedge clk);
        srst = 1'b0;
        wait_done(9, 100);
        chk_done(8, 32'h9000, 16'd4, 1'b0);
        chk_wr(14, 32'h9000, 32'h9000_00D0, 4'hF);
        chk("t6_total_pops", 64'(pops), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
